// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU register-file widths and types
package cpu_pkg;

    localparam int REG_W  = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0]           regaddr_t;
    typedef logic [REG_W-1:0]            word_t;
    typedef logic [NREG-1:0][REG_W-1:0]  regarray_t;

endpackage

// File: rtl/decoder5to32.sv
// rtl/decoder5to32.sv - 5-to-32 one-hot decoder with enable, bit 0 masked
module decoder5to32
    import cpu_pkg::*;
(
    input  logic        en,
    input  regaddr_t    addr,
    output logic [31:0] onehot
);

    // Register 0 is hardwired, so its select line is never raised.
    always_comb begin
        onehot = '0;
        if (en && (addr != '0)) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_sb.sv
// rtl/reg_bank_sb.sv - register bank with busy scoreboard, optional REG_BANK_BYPASS_EN forwarding
module reg_bank_sb
    import cpu_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int REG_W = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wb_en,
    input  regaddr_t                    wb_addr,
    input  logic [REG_W-1:0]            wb_data,
    input  logic                        iss_en,
    input  regaddr_t                    iss_dst,
    input  regaddr_t                    rs_addr,
    input  regaddr_t                    rt_addr,
    output logic [NREG-1:0][REG_W-1:0]  regs_out,
    output logic [NREG-1:0]             busy,
    output logic                        stall
);

    regarray_t          regs_q;
    logic [NREG-1:0]    busy_q;
    logic [NREG-1:0]    busy_d;
    logic [NREG-1:0]    wb_hot;
    logic [NREG-1:0]    iss_hot;
    logic [NREG-1:0]    busy_eff;

    decoder5to32 u_wb_dec (
        .en     (wb_en),
        .addr   (wb_addr),
        .onehot (wb_hot)
    );

    decoder5to32 u_iss_dec (
        .en     (iss_en),
        .addr   (iss_dst),
        .onehot (iss_hot)
    );

    // Write-back retires a pending write; a same-cycle issue re-arms it since it is newer.
    always_comb begin
        busy_d = (busy_q & ~wb_hot) | iss_hot;
    end

    // Register storage; row 0 is never selected by the decoder and so stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_hot[i]) begin
                    regs_q[i] <= wb_data;
                end
            end
        end
    end

    // Scoreboard of registers with an in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Operand array to the read muxes, optionally overlaid with this cycle's write-back.
    always_comb begin
        regs_out = regs_q;
`ifdef REG_BANK_BYPASS_EN
        for (int i = 0; i < NREG; i++) begin
            if (wb_hot[i]) begin
                regs_out[i] = wb_data;
            end
        end
`endif
    end

    // Busy view used for hazard detection; a forwarded source is no longer a hazard.
    always_comb begin
`ifdef REG_BANK_BYPASS_EN
        busy_eff = busy_q & ~wb_hot;
`else
        busy_eff = busy_q;
`endif
    end

    // Hazard detect on both decode sources; register 0 never stalls.
    always_comb begin
        stall = (busy_eff[rs_addr] & (rs_addr != '0)) |
                (busy_eff[rt_addr] & (rt_addr != '0));
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_reg_bank_sb.sv
// tb/tb_reg_bank_sb.sv - directed self-checking bench for reg_bank_sb
module tb_reg_bank_sb;

    logic              clk;
    logic              rst_n;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [31:0]       wb_data;
    logic              iss_en;
    logic [4:0]        iss_dst;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [31:0][31:0] regs_out;
    logic [31:0]       busy;
    logic              stall;

    int checks;
    int errors;

    reg_bank_sb #(.NREG(32), .REG_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .iss_en   (iss_en),
        .iss_dst  (iss_dst),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .regs_out (regs_out),
        .busy     (busy),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        iss_en  = 1'b0;
        iss_dst = '0;
        rs_addr = '0;
        rt_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rs_addr = 5'd3;
        rt_addr = 5'd4;
        rst_n   = 1'b0;
        #12;
        checks++;
        if (regs_out !== '0) begin
            errors++;
            $display("FAIL reset_regs got %h want 0", regs_out);
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++;
            $display("FAIL reset_busy got %h want 00000000", busy);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got %b want 0", stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        cycle();
    endtask

    task automatic test_reset_mid();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        iss_en = 1'b1; iss_dst = 5'd6;
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (regs_out[5] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL mid_r5_written got %h want deadbeef", regs_out[5]);
        end
        checks++;
        if (busy !== 32'h0000_0040) begin
            errors++;
            $display("FAIL mid_busy6 got %h want 00000040", busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (regs_out[5] !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_r5 got %h want 00000000", regs_out[5]);
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_busy got %h want 00000000", busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_r0();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_dst = 5'd0;
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (regs_out[0] !== 32'h0) begin
            errors++;
            $display("FAIL r0_row got %h want 00000000", regs_out[0]);
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++;
            $display("FAIL r0_busy got %h want 00000000", busy);
        end
    endtask

    task automatic test_raw();
        iss_en = 1'b1; iss_dst = 5'd7;
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (busy !== 32'h0000_0080) begin
            errors++;
            $display("FAIL raw_busy7 got %h want 00000080", busy);
        end
        rs_addr = 5'd7;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL raw_stall_pending got %b want 1", stall);
        end
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h12345678;
        #1;
`ifdef REG_BANK_BYPASS_EN
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL raw_stall_wbcycle got %b want 0", stall);
        end
        checks++;
        if (regs_out[7] !== 32'h12345678) begin
            errors++;
            $display("FAIL raw_row7_wbcycle got %h want 12345678", regs_out[7]);
        end
`else
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL raw_stall_wbcycle got %b want 1", stall);
        end
        checks++;
        if (regs_out[7] !== 32'h0) begin
            errors++;
            $display("FAIL raw_row7_wbcycle got %h want 00000000", regs_out[7]);
        end
`endif
        cycle();
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL raw_stall_after got %b want 0", stall);
        end
        checks++;
        if (regs_out[7] !== 32'h12345678) begin
            errors++;
            $display("FAIL raw_row7_after got %h want 12345678", regs_out[7]);
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++;
            $display("FAIL raw_busy_after got %h want 00000000", busy);
        end
        idle_inputs();
    endtask

    task automatic test_same_reg();
        iss_en = 1'b1; iss_dst = 5'd9;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5A5A5;
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (regs_out[9] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL same_row9 got %h want a5a5a5a5", regs_out[9]);
        end
        checks++;
        if (busy !== 32'h0000_0200) begin
            errors++;
            $display("FAIL same_busy9 got %h want 00000200", busy);
        end
    endtask

    task automatic test_diff_reg();
        iss_en = 1'b1; iss_dst = 5'd4;
        cycle();
        iss_en = 1'b1; iss_dst = 5'd3;
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h00000044;
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (busy !== 32'h0000_0208) begin
            errors++;
            $display("FAIL diff_busy got %h want 00000208", busy);
        end
        checks++;
        if (regs_out[4] !== 32'h00000044) begin
            errors++;
            $display("FAIL diff_row4 got %h want 00000044", regs_out[4]);
        end
        rs_addr = 5'd3; rt_addr = 5'd4;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL diff_stall_rs3 got %b want 1", stall);
        end
        rs_addr = 5'd4; rt_addr = 5'd0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL diff_stall_rs4 got %b want 0", stall);
        end
        rs_addr = 5'd0; rt_addr = 5'd9;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL diff_stall_rt9 got %b want 1", stall);
        end
        idle_inputs();
    endtask

    task automatic test_fill();
        logic [31:0] want;
        for (int i = 1; i < 32; i++) begin
            wb_en   = 1'b1;
            wb_addr = 5'(i);
            wb_data = 32'(i) * 32'h01010101;
            cycle();
        end
        idle_inputs();
        #1;
        for (int i = 0; i < 32; i++) begin
            want = 32'(i) * 32'h01010101;
            checks++;
            if (regs_out[i] !== want) begin
                errors++;
                $display("FAIL fill_row%0d got %h want %h", i, regs_out[i], want);
            end
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++;
            $display("FAIL fill_busy got %h want 00000000", busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_mid();
        test_r0();
        test_raw();
        test_same_reg();
        test_diff_reg();
        test_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_sb.md
# reg_bank_sb

Architectural register bank with a busy-bit scoreboard for the 32-bit CPU. Holds 32 × 32-bit registers, accepts one write-back per cycle, and drives the full 32 × 32 register array to the 32-to-1 operand read multiplexers that sit directly downstream. It also tracks destination registers of in-flight instructions and raises a stall when the decode stage's sources are still pending.

## Interface
Parameters:
- NREG, 32, number of registers; fixed at 32 to match the 5-bit register address.
- REG_W, 32, register width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_en  in  1  write-back strobe.
- wb_addr  in  5  write-back destination register.
- wb_data  in  32  write-back data.
- iss_en  in  1  decode issues an instruction that will write a register.
- iss_dst  in  5  destination register of the issuing instruction.
- rs_addr  in  5  decode source register A, checked for hazard.
- rt_addr  in  5  decode source register B, checked for hazard.
- regs_out  out  32×32  packed [31:0][31:0] register array; row i is register i. Feeds the operand read mux.
- busy  out  32  scoreboard bits; bit i = register i has a pending write.
- stall  out  1  hazard on rs_addr or rt_addr; decode must hold.

## Operation
- Storage: 32 registers, each 32 bits wide. Register 0 always reads as 0. Writes to register 0 are dropped. busy[0] is always 0.
- Write-back: when wb_en=1 and wb_addr≠0, register wb_addr is loaded with wb_data at the clock edge. busy[wb_addr] clears at the same edge.
- Issue: when iss_en=1 and iss_dst≠0, busy[iss_dst] sets at the clock edge.
- Issue and write-back to the same register in the same cycle: busy ends at 1, because the newer in-flight write wins. The data write still takes effect.
- Issue and write-back to different registers in the same cycle: both updates apply.
- Write-back to a register whose busy bit is 0 (for example a store-free path): data is written and busy stays 0. This is not an error.
- Hazard: stall = (busy[rs_addr] & rs_addr≠0) | (busy[rt_addr] & rt_addr≠0). Purely combinational from current state and addresses, with the bypass adjustment described under Configuration.
- stall does not gate iss_en. Decode is responsible for deasserting iss_en while stall=1.

## Timing
- Reset (rst_n low, asynchronous): every register = 32'h0, busy = 32'h0, stall = 0. This holds immediately and for as long as reset is asserted.
- Reset release takes effect at the first clock edge with rst_n=1.
- Reset asserted mid-operation discards all pending busy bits and register contents.
- Write latency (no bypass): a value written at edge N appears on regs_out after edge N, i.e. in cycle N+1.
- Busy latency: iss_en in cycle N → busy bit set and visible in cycle N+1.
- Combinational paths: rs_addr/rt_addr → stall, and state → regs_out. No input → output combinational path exists except those listed here and under Configuration.

## Configuration
- REG_BANK_BYPASS_EN defined: write-back data is forwarded in the same cycle.
  - When wb_en=1 and wb_addr≠0, row wb_addr of regs_out shows wb_data combinationally.
  - stall ignores busy[wb_addr] for a source equal to wb_addr during that cycle.
  - Result: a dependent instruction issues in the write-back cycle with no bubble.
- REG_BANK_BYPASS_EN undefined: regs_out reflects stored state only, and stall uses stored busy bits only. This costs one extra stall cycle on a read-after-write dependency.

## Structure
- Shared package cpu_pkg holds:
  - REG_W = 32, NREG = 32, REG_AW = 5;
  - typedef regaddr_t (logic [4:0]);
  - typedef word_t (logic [31:0]);
  - typedef regarray_t (logic [31:0][31:0]), also used by the operand read mux.
- One sub-module, decoder5to32: one-hot decode with enable. Instantiated twice, once for the write-back decode and once for the issue decode. It masks out bit 0.

## Test plan
- Reset → regs_out all 0, busy=0, stall=0. Then assert rst_n=0 mid-run after writing r5=32'hDEADBEEF → r5 reads 0 immediately (before any clock edge).
- wb_en=1, wb_addr=0, wb_data=32'hFFFFFFFF → row 0 stays 0 and busy[0] stays 0. Same cycle with iss_dst=0 → no busy bit sets.
- iss_en, iss_dst=7 → busy[7]=1 next cycle. Then rs_addr=7 → stall=1. Then wb r7=32'h12345678:
  - without REG_BANK_BYPASS_EN: stall=1 in the wb cycle and 0 after; r7 reads 32'h12345678 in cycle N+1.
  - with REG_BANK_BYPASS_EN: stall=0 and row 7 = 32'h12345678 in the wb cycle itself.
- Same cycle: iss_dst=9 and wb_addr=9 with data 32'hA5A5A5A5 → r9=32'hA5A5A5A5 and busy[9]=1 afterwards.
- Same cycle: iss_dst=3 and wb_addr=4 (busy[4] previously 1) → busy[3]=1 and busy[4]=0. Then rs_addr=3, rt_addr=4 → stall=1. Then rs_addr=4, rt_addr=0 → stall=0.
- Write r1..r31 with value i×32'h01010101, read back every row of regs_out → exact match; row 0 = 0.
